// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Holds the FSM state encoding, default width and counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DIV_DEFAULT_WIDTH = 4;

    function automatic int clog2(input int value);
        int bits;
        int rest;
        bits = 0;
        rest = value - 1;
        while (rest > 0) begin
            bits++;
            rest = rest >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle of the divider.
// master drives operands and start, slave returns status and results.
interface div_seq_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Shifts in the next dividend bit and trial-subtracts the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // One extra bit keeps the trial difference's sign visible.
    assign shifted = {rem_in, dvd_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];

    // Restore by keeping the shifted value when the subtraction underflows.
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Optional two's-complement operands when DIV_SIGNED_EN is defined.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    div_seq_if.slave  bus
);

    localparam int CW = clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] dvd_acc;
    logic [WIDTH-1:0] dsr;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic             zero_div;

    assign zero_div = (bus.divisor == '0);

`ifdef DIV_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic q_neg;
    logic r_neg;

    assign a_neg = bus.dividend[WIDTH-1];
    assign b_neg = bus.divisor[WIDTH-1];

    // Most-negative magnitude wraps to itself, which is its correct unsigned value.
    assign a_mag = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag = b_neg ? -bus.divisor  : bus.divisor;
`else
    assign a_mag = bus.dividend;
    assign b_mag = bus.divisor;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_acc),
        .dvd_bit (dvd_acc[WIDTH-1]),
        .divisor (dsr),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // The final quotient bit joins the shifted-out accumulator bits.
    assign q_raw = {dvd_acc[WIDTH-2:0], q_bit};

`ifdef DIV_SIGNED_EN
    assign q_fin = q_neg ? -q_raw    : q_raw;
    assign r_fin = r_neg ? -rem_next : rem_next;
`else
    assign q_fin = q_raw;
    assign r_fin = rem_next;
`endif

`ifdef DIV_SIGNED_EN
    // Sign fix-up flags are latched with the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state != CALC && bus.start) begin
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
        end
    end
`endif

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rem_acc <= '0;
            dvd_acc <= '0;
            dsr     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start && !zero_div) begin
                        rem_acc <= '0;
                        dvd_acc <= a_mag;
                        dsr     <= b_mag;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= CALC;
                    end else if (bus.start) begin
                        quot_q  <= '1;
                        rem_q   <= bus.dividend;
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state   <= IDLE;
                    end
                end
                CALC: begin
                    rem_acc <= rem_next;
                    dvd_acc <= q_raw;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        quot_q <= q_fin;
                        rem_q  <= r_fin;
                        dbz_q  <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq at WIDTH=4.
// Table of hand-computed results plus reset, back-to-back and sweep sequences.
module tb_div_seq;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    div_seq_if #(.WIDTH(W)) bus ();

    div_seq #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation from a point #1 after an edge; return at done.
    task automatic run_op(
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        output logic [W-1:0] q,
        output logic [W-1:0] r,
        output logic         dz,
        output int           lat,
        output int           bcnt
    );
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.done) begin
            chk("done_timeout", 0, 1);
        end
        q  = bus.quotient;
        r  = bus.remainder;
        dz = bus.div_by_zero;
    endtask

    function automatic void model(
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        output logic [W-1:0] q,
        output logic [W-1:0] r,
        output logic         dz
    );
        int qi;
        int ri;
`ifdef DIV_SIGNED_EN
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        qi = (b == 0) ? 0 : int'(sa) / int'(sb);
        ri = (b == 0) ? 0 : int'(sa) % int'(sb);
`else
        qi = (b == 0) ? 0 : int'(a) / int'(b);
        ri = (b == 0) ? 0 : int'(a) % int'(b);
`endif
        q  = (b == 0) ? '1 : qi[W-1:0];
        r  = (b == 0) ? a  : ri[W-1:0];
        dz = (b == 0);
    endfunction

    vec_t tbl [$];

    initial begin
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         dz;
        logic         edz;
        int           lat;
        int           bcnt;
        int           seen;

        checks = 0;
        errors = 0;

`ifdef DIV_SIGNED_EN
        tbl.push_back('{a: 4'b1001, b: 4'd2,    q: 4'b1101, r: 4'b1111, dz: 1'b0});
        tbl.push_back('{a: 4'b1000, b: 4'b1111, q: 4'b1000, r: 4'd0,    dz: 1'b0});
        tbl.push_back('{a: 4'd7,    b: 4'd0,    q: 4'd15,   r: 4'd7,    dz: 1'b1});
        tbl.push_back('{a: 4'd6,    b: 4'b1101, q: 4'b1110, r: 4'd0,    dz: 1'b0});
        tbl.push_back('{a: 4'd5,    b: 4'd2,    q: 4'd2,    r: 4'd1,    dz: 1'b0});
`else
        tbl.push_back('{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, dz: 1'b0});
        tbl.push_back('{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7, dz: 1'b1});
        tbl.push_back('{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0});
        tbl.push_back('{a: 4'd2,  b: 4'd9,  q: 4'd0,  r: 4'd2, dz: 1'b0});
        tbl.push_back('{a: 4'd14, b: 4'd5,  q: 4'd2,  r: 4'd4, dz: 1'b0});
        tbl.push_back('{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0});
        tbl.push_back('{a: 4'd1,  b: 4'd15, q: 4'd0,  r: 4'd1, dz: 1'b0});
        tbl.push_back('{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0, dz: 1'b1});
`endif

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n        = 1'b0;

        #2;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_quot", int'(bus.quotient), 0);
        chk("rst_rem",  int'(bus.remainder), 0);
        chk("rst_dbz",  int'(bus.div_by_zero), 0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table.
        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, q, r, dz, lat, bcnt);
            chk($sformatf("tbl%0d_quot", i), int'(q), int'(tbl[i].q));
            chk($sformatf("tbl%0d_rem", i),  int'(r), int'(tbl[i].r));
            chk($sformatf("tbl%0d_dbz", i),  int'(dz), int'(tbl[i].dz));
            chk($sformatf("tbl%0d_lat", i),  lat, tbl[i].dz ? 0 : W);
            chk($sformatf("tbl%0d_busy", i), bcnt, tbl[i].dz ? 0 : W);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_pulse", i), int'(bus.done), 0);
        end

        // Outputs hold while idle.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_quot", int'(bus.quotient), int'(tbl[tbl.size()-1].q));
        chk("hold_rem",  int'(bus.remainder), int'(tbl[tbl.size()-1].r));

        // Reset mid-calculation discards the operation.
        run_op(4'd13, 4'd3, q, r, dz, lat, bcnt);
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 4'd13;
        bus.divisor  = 4'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy_pre", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        chk("mid_rst_quot", int'(bus.quotient), 0);
        chk("mid_rst_rem",  int'(bus.remainder), 0);
        chk("mid_rst_dbz",  int'(bus.div_by_zero), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        chk("mid_rst_no_done", seen, 0);

        // Back-to-back with start held high through CALC and DONE.
        bus.start    = 1'b1;
        bus.dividend = 4'd2;
        bus.divisor  = 4'd9;
        @(posedge clk);
        #1;
        bus.dividend = 4'd14;
        bus.divisor  = 4'd5;
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        model(4'd2, 4'd9, eq, er, edz);
        chk("b2b1_lat",  lat, W);
        chk("b2b1_quot", int'(bus.quotient), int'(eq));
        chk("b2b1_rem",  int'(bus.remainder), int'(er));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b2_busy", int'(bus.busy), 1);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        model(4'd14, 4'd5, eq, er, edz);
        chk("b2b2_lat",  lat, W);
        chk("b2b2_quot", int'(bus.quotient), int'(eq));
        chk("b2b2_rem",  int'(bus.remainder), int'(er));
        @(posedge clk);
        #1;

        // Start pulses and operand changes during CALC are ignored.
        bus.start    = 1'b1;
        bus.dividend = 4'd13;
        bus.divisor  = 4'd3;
        @(posedge clk);
        #1;
        lat = 0;
        while (!bus.done && lat < 20) begin
            bus.start    = ~bus.start;
            bus.dividend = 4'($urandom_range(0, 15));
            bus.divisor  = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        model(4'd13, 4'd3, eq, er, edz);
        chk("ign_lat",  lat, W);
        chk("ign_quot", int'(bus.quotient), int'(eq));
        chk("ign_rem",  int'(bus.remainder), int'(er));
        repeat (2) @(posedge clk);
        #1;

        // Full sweep of operand pairs against the reference.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), q, r, dz, lat, bcnt);
                model(4'(a), 4'(b), eq, er, edz);
                chk($sformatf("sw_%0d_%0d_quot", a, b), int'(q), int'(eq));
                chk($sformatf("sw_%0d_%0d_rem", a, b),  int'(r), int'(er));
                chk($sformatf("sw_%0d_%0d_dbz", a, b),  int'(dz), int'(edz));
                chk($sformatf("sw_%0d_%0d_lat", a, b),  lat, edz ? 0 : W);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
